// File: rtl/collect_skewed_array_if.sv
// Handshake bundle for the skewed-stream collector.
// The producer/consumer side uses master; the collector uses slave.
interface collect_skewed_array_if #(
  parameter int BW = 8,
  parameter int N  = 5
);
  logic                        iValid;
  logic [N-1:0][BW-1:0]        iLane;
  logic                        iAck;
  logic [N-1:0][N-1:0][BW-1:0] oMatrix;
  logic                        oBusy;
  logic                        oDone;
  logic                        oSkewErr;

  modport master (
    output iValid, iLane, iAck,
    input  oMatrix, oBusy, oDone, oSkewErr
  );

  modport slave (
    input  iValid, iLane, iAck,
    output oMatrix, oBusy, oDone, oSkewErr
  );
endinterface

// File: rtl/collect_skewed_array.sv
// Reassembles an NxN matrix from a diagonally skewed N-lane stream.
// Lane i carries element (i,k) on beat i+k; other slots must be zero.
module collect_skewed_array #(
  parameter int BW        = 8,
  parameter int N         = 5,
  parameter int TRANSPOSE = 0
) (
  input  logic clk,
  input  logic rst,
  collect_skewed_array_if.slave bus
);
  localparam int CW = (2*N-1 > 1) ? $clog2(2*N-1) : 1;
  localparam logic [CW-1:0] LAST = CW'(2*N-2);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t                      state_q;
  logic [CW-1:0]               cnt_q;
  logic [N-1:0][N-1:0][BW-1:0] mat_q;
  logic [N-1:0][N-1:0][BW-1:0] mat_d;
  logic                        err_q;
  logic                        err_d;
  logic                        accept;
  logic [CW-1:0]               beat;
  logic [N-1:0]                hit;

  assign accept = bus.iValid && (state_q != DONE);
  assign beat   = (state_q == IDLE) ? '0 : cnt_q;

  // Each lane is in-window for N consecutive beats; anything else is padding.
  always_comb begin
    mat_d = mat_q;
    err_d = err_q;
    hit   = '0;
    if (accept) begin
      if (state_q == IDLE) err_d = 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(beat) == i + k) begin
            hit[i] = 1'b1;
            if (TRANSPOSE != 0) mat_d[k][i] = bus.iLane[i];
            else                mat_d[i][k] = bus.iLane[i];
          end
        end
        if (!hit[i] && (bus.iLane[i] != '0)) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      mat_q <= mat_d;
      err_q <= err_d;
      unique case (state_q)
        IDLE: begin
          if (bus.iValid) begin
            if (N == 1) begin
              state_q <= DONE;
            end else begin
              state_q <= COLLECT;
              cnt_q   <= CW'(1);
            end
          end
        end
        COLLECT: begin
          if (bus.iValid) begin
            if (cnt_q == LAST) begin
              state_q <= DONE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          if (bus.iAck) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oMatrix  = mat_q;
  assign bus.oBusy    = (state_q == COLLECT);
  assign bus.oDone    = (state_q == DONE);
  assign bus.oSkewErr = err_q;
endmodule

// File: tb/tb_collect_skewed_array.sv
// Directed bench for collect_skewed_array, N=3 BW=8.
// Two instances share stimulus: one row-major, one transposed.
module tb_collect_skewed_array;
  typedef logic [2:0][7:0]      lanes_t;
  typedef logic [2:0][2:0][7:0] mat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  collect_skewed_array_if #(.BW(8), .N(3)) b0 ();
  collect_skewed_array_if #(.BW(8), .N(3)) b1 ();

  assign b1.iValid = b0.iValid;
  assign b1.iLane  = b0.iLane;
  assign b1.iAck   = b0.iAck;

  collect_skewed_array #(.BW(8), .N(3), .TRANSPOSE(0)) u_row (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  collect_skewed_array #(.BW(8), .N(3), .TRANSPOSE(1)) u_col (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  lanes_t STR [5];
  mat_t   M0;
  mat_t   MT;
  mat_t   M16;
  mat_t   MH;

  function automatic lanes_t ln(input logic [7:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  function automatic lanes_t offs(input lanes_t l, input logic [7:0] d);
    lanes_t r;
    r = l;
    for (int i = 0; i < 3; i++)
      if (l[i] != 8'd0) r[i] = l[i] + d;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input lanes_t l);
    b0.iValid = 1'b1;
    b0.iLane  = l;
    step();
    b0.iValid = 1'b0;
    b0.iLane  = '0;
  endtask

  task automatic ack();
    b0.iAck = 1'b1;
    step();
    b0.iAck = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if (b0.oMatrix !== '0) begin
      n_bad++;
      $display("FAIL rst_mat: got %h want 0", b0.oMatrix);
    end
    n_cmp++;
    if (b1.oMatrix !== '0) begin
      n_bad++;
      $display("FAIL rst_mat_t: got %h want 0", b1.oMatrix);
    end
    n_cmp++;
    if (b0.oBusy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy: got %b want 0", b0.oBusy);
    end
    n_cmp++;
    if (b0.oDone !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_done: got %b want 0", b0.oDone);
    end
    n_cmp++;
    if (b0.oSkewErr !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_err: got %b want 0", b0.oSkewErr);
    end
  endtask

  task automatic test_contiguous();
    send(STR[0]);
    send(STR[1]);
    n_cmp++;
    if (b0.oMatrix[0][1] !== 8'd2 || b0.oMatrix[1][0] !== 8'd4) begin
      n_bad++;
      $display("FAIL part_row: got %h/%h want 02/04",
               b0.oMatrix[0][1], b0.oMatrix[1][0]);
    end
    n_cmp++;
    if (b1.oMatrix[1][0] !== 8'd2) begin
      n_bad++;
      $display("FAIL part_col: got %h want 02", b1.oMatrix[1][0]);
    end
    send(STR[2]);
    send(STR[3]);
    n_cmp++;
    if (b0.oDone !== 1'b0 || b0.oBusy !== 1'b1) begin
      n_bad++;
      $display("FAIL early_done: got done=%b busy=%b want 0/1",
               b0.oDone, b0.oBusy);
    end
    send(STR[4]);
    n_cmp++;
    if (b0.oDone !== 1'b1 || b0.oBusy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_5: got done=%b busy=%b want 1/0",
               b0.oDone, b0.oBusy);
    end
    n_cmp++;
    if (b0.oMatrix !== M0) begin
      n_bad++;
      $display("FAIL mat_row: got %h want %h", b0.oMatrix, M0);
    end
    n_cmp++;
    if (b1.oMatrix !== MT) begin
      n_bad++;
      $display("FAIL mat_col: got %h want %h", b1.oMatrix, MT);
    end
    n_cmp++;
    if (b0.oSkewErr !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_err: got %b want 0", b0.oSkewErr);
    end
    ack();
    n_cmp++;
    if (b0.oDone !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_drop: got %b want 0", b0.oDone);
    end
  endtask

  task automatic test_gaps();
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(STR[0]);
    send(STR[1]);
    for (int g = 0; g < 2; g++) begin
      step();
      n_cmp++;
      if (b0.oBusy !== 1'b1) begin
        n_bad++;
        $display("FAIL gap1_busy: got %b want 1", b0.oBusy);
      end
    end
    send(STR[2]);
    send(STR[3]);
    for (int g = 0; g < 2; g++) begin
      step();
      n_cmp++;
      if (b0.oBusy !== 1'b1) begin
        n_bad++;
        $display("FAIL gap2_busy: got %b want 1", b0.oBusy);
      end
    end
    n_cmp++;
    if (b0.oDone !== 1'b0) begin
      n_bad++;
      $display("FAIL gap_early: got %b want 0", b0.oDone);
    end
    send(STR[4]);
    n_cmp++;
    if (b0.oDone !== 1'b1) begin
      n_bad++;
      $display("FAIL gap_done9: got %b want 1", b0.oDone);
    end
    n_cmp++;
    if (b0.oMatrix !== M0 || b1.oMatrix !== MT) begin
      n_bad++;
      $display("FAIL gap_mat: got %h/%h want %h/%h",
               b0.oMatrix, b1.oMatrix, M0, MT);
    end
    ack();
  endtask

  task automatic test_skew();
    send(ln(8'd1, 8'd0, 8'hAA));
    n_cmp++;
    if (b0.oSkewErr !== 1'b1) begin
      n_bad++;
      $display("FAIL skew_set: got %b want 1", b0.oSkewErr);
    end
    for (int b = 1; b < 5; b++) send(STR[b]);
    n_cmp++;
    if (b0.oDone !== 1'b1 || b0.oSkewErr !== 1'b1) begin
      n_bad++;
      $display("FAIL skew_hold: got done=%b err=%b want 1/1",
               b0.oDone, b0.oSkewErr);
    end
    n_cmp++;
    if (b0.oMatrix !== M0 || b1.oMatrix !== MT) begin
      n_bad++;
      $display("FAIL skew_mat: got %h/%h want %h/%h",
               b0.oMatrix, b1.oMatrix, M0, MT);
    end
    ack();
    send(STR[0]);
    n_cmp++;
    if (b0.oSkewErr !== 1'b0) begin
      n_bad++;
      $display("FAIL skew_clr: got %b want 0", b0.oSkewErr);
    end
    for (int b = 1; b < 5; b++) send(STR[b]);
    ack();
  endtask

  task automatic test_handshake();
    for (int b = 0; b < 5; b++) send(offs(STR[b], 8'd16));
    n_cmp++;
    if (b0.oDone !== 1'b1 || b0.oMatrix !== M16) begin
      n_bad++;
      $display("FAIL hs_mat16: got done=%b %h want 1 %h",
               b0.oDone, b0.oMatrix, M16);
    end
    b0.iValid = 1'b1;
    b0.iLane  = ln(8'h55, 8'd0, 8'd0);
    step();
    step();
    step();
    n_cmp++;
    if (b0.oDone !== 1'b1 || b0.oMatrix !== M16) begin
      n_bad++;
      $display("FAIL hs_hold: got done=%b %h want 1 %h",
               b0.oDone, b0.oMatrix, M16);
    end
    b0.iAck = 1'b1;
    step();
    b0.iAck = 1'b0;
    n_cmp++;
    if (b0.oDone !== 1'b0 || b0.oBusy !== 1'b0) begin
      n_bad++;
      $display("FAIL hs_ackedge: got done=%b busy=%b want 0/0",
               b0.oDone, b0.oBusy);
    end
    step();
    b0.iValid = 1'b0;
    b0.iLane  = '0;
    n_cmp++;
    if (b0.oBusy !== 1'b1 || b0.oMatrix[0][0] !== 8'h55
        || b0.oMatrix[0][1] !== 8'd18) begin
      n_bad++;
      $display("FAIL hs_beat0: got busy=%b %h %h want 1 55 12",
               b0.oBusy, b0.oMatrix[0][0], b0.oMatrix[0][1]);
    end
    for (int b = 1; b < 5; b++) send(STR[b]);
    n_cmp++;
    if (b0.oDone !== 1'b1 || b0.oMatrix !== MH) begin
      n_bad++;
      $display("FAIL hs_final: got done=%b %h want 1 %h",
               b0.oDone, b0.oMatrix, MH);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    send(ln(8'd1, 8'd0, 8'hAA));
    send(STR[1]);
    send(STR[2]);
    n_cmp++;
    if (b0.oSkewErr !== 1'b1 || b0.oBusy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre: got err=%b busy=%b want 1/1",
               b0.oSkewErr, b0.oBusy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (b0.oMatrix !== '0 || b1.oMatrix !== '0) begin
      n_bad++;
      $display("FAIL mid_mat: got %h/%h want 0",
               b0.oMatrix, b1.oMatrix);
    end
    n_cmp++;
    if (b0.oBusy !== 1'b0 || b0.oDone !== 1'b0 || b0.oSkewErr !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_flags: got busy=%b done=%b err=%b want 0/0/0",
               b0.oBusy, b0.oDone, b0.oSkewErr);
    end
    for (int b = 0; b < 5; b++) send(STR[b]);
    n_cmp++;
    if (b0.oDone !== 1'b1 || b0.oMatrix !== M0 || b1.oMatrix !== MT) begin
      n_bad++;
      $display("FAIL mid_fresh: got done=%b %h/%h want 1 %h/%h",
               b0.oDone, b0.oMatrix, b1.oMatrix, M0, MT);
    end
    ack();
  endtask

  initial begin
    b0.iValid = 1'b0;
    b0.iLane  = '0;
    b0.iAck   = 1'b0;
    STR[0] = ln(8'd1, 8'd0, 8'd0);
    STR[1] = ln(8'd2, 8'd4, 8'd0);
    STR[2] = ln(8'd3, 8'd5, 8'd7);
    STR[3] = ln(8'd0, 8'd6, 8'd8);
    STR[4] = ln(8'd0, 8'd0, 8'd9);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        M0[r][c]  = 8'(3*r + c + 1);
        MT[r][c]  = 8'(3*c + r + 1);
        M16[r][c] = 8'(3*r + c + 17);
      end
    end
    MH       = M0;
    MH[0][0] = 8'h55;

    test_reset();
    test_contiguous();
    test_gaps();
    test_skew();
    test_handshake();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/collect_skewed_array.md
# collect_skewed_array

Reassembles an N×N matrix from a diagonally skewed N-lane stream, inverting the row/column skew applied when feeding the systolic array. It sits at the systolic array output boundary, or on any skewed bus, and presents the deskewed result as a parallel matrix with a completion handshake. Lane i carries element (i,k) on beat i+k. Every other beat of lane i is zero padding.

## Interface
- BW, 8, element width in bits
- N, 5, lane count and matrix dimension
- TRANSPOSE, 0, 0: lane i fills row i; 1: lane i fills column i (oMatrix[k][i])

- clk  input  1  clock, rising-edge
- rst  input  1  synchronous reset, active-high
- iValid  input  1  current beat on iLane is valid
- iLane  input  [BW-1:0] x N  skewed lane data, one element per lane per beat
- iAck  input  1  consumer has taken the result; releases DONE
- oMatrix  output  [BW-1:0] x N x N  deskewed matrix, registered
- oBusy  output  1  collection in progress
- oDone  output  1  matrix complete and stable
- oSkewErr  output  1  nonzero data seen in a padding slot during the current collection

## Operation
- One clock domain. Reset is synchronous and active-high.
- The FSM has three states: IDLE, COLLECT, DONE.
- Beat counter cnt is 0..2N-2, with width $clog2(2N-1) (at least 1 bit).
- A beat is accepted when iValid=1 and the state is IDLE or COLLECT.
  - IDLE: the accepted beat is beat 0, and the state moves to COLLECT. If N=1 it moves straight to DONE.
  - COLLECT: each accepted beat increments cnt.
  - COLLECT: accepting beat 2N-2 moves the state to DONE and resets cnt to 0.
- Gaps (iValid=0) are allowed inside COLLECT. State and cnt hold during a gap.
- Per-lane window: on beat b, lane i is in-window when i ≤ b ≤ i+N-1.
  - In-window, with TRANSPOSE=0: oMatrix[i][b-i] ← iLane[i].
  - In-window, with TRANSPOSE=1: oMatrix[b-i][i] ← iLane[i].
  - Out-of-window with iLane[i]≠0: oSkewErr is set, sticky for the collection. The data is discarded.
- Accepting beat 0 clears oSkewErr before that beat is evaluated. An error on beat 0 itself still sets it.
- DONE: iValid is ignored, and oMatrix and oSkewErr hold. iAck=1 moves the state to IDLE.
- oMatrix keeps its contents in IDLE. The next collection overwrites every entry, because each (row, col) is in-window exactly once.
- Outputs: oBusy = (state==COLLECT). oDone = (state==DONE).

## Timing
- Reset values: state=IDLE, cnt=0, oMatrix all zeros, oBusy=0, oDone=0, oSkewErr=0.
- An oMatrix entry updates on the same clock edge that accepts its beat and is visible the following cycle.
- oDone rises one cycle after the edge accepting beat 2N-2. With no gaps, oDone is high 2N-1 cycles after the first accepted beat.
- On the cycle oDone first reads 1, all N² entries are final.
- iAck is sampled only in DONE. oDone drops on the cycle after the iAck edge.
- A beat with iValid=1 on the same edge as iAck is not accepted, because the state is still DONE. The earliest new beat 0 is one cycle after iAck.
- iAck in IDLE or COLLECT is ignored.
- Reset mid-collection returns the block to its reset values on the next edge. Partial data is discarded.
- The block has no backpressure. The producer must not send beats while oDone=1; such beats are dropped.

## Test plan
- N=3, BW=8, TRANSPOSE=0, contiguous stream:
  - Stimulus: beats {1,0,0},{2,4,0},{3,5,7},{0,6,8},{0,0,9}.
  - Response: oMatrix=[[1,2,3],[4,5,6],[7,8,9]]; oDone high exactly 5 cycles after beat 0; oSkewErr=0.
- Same stream with TRANSPOSE=1 -> oMatrix=[[1,4,7],[2,5,8],[3,6,9]].
- Same stream with iValid dropped for 2 cycles after beat 1 and again after beat 3:
  - Identical matrix.
  - oDone high 9 cycles after beat 0.
  - oBusy stays high through the gaps.
- Padding violation: beat 0 lane 2 = 0xAA.
  - oSkewErr=1 from the next cycle and held through DONE.
  - Matrix is unaffected by 0xAA.
  - oSkewErr clears on the next collection's beat 0 when that beat is clean.
- Handshake:
  - iValid=1 held through DONE with no iAck: oMatrix unchanged, no beat accepted.
  - iValid=1 on the iAck edge: that beat is ignored.
  - iValid=1 on the following edge: accepted as beat 0 of a new collection.
- Reset mid-collection: assert rst after beat 2.
  - Next cycle: oMatrix all zeros, oBusy=0, oDone=0, oSkewErr=0.
  - A fresh full stream then completes correctly.
